// File: rtl/kbd_pkg.sv
// Shared encodings and helpers for the matrix keypad scanner.
// Key codes are row*4 + col, so a code splits back into {row, col}.
package kbd_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } deb_state_t;

   typedef enum logic [1:0] {
      NONE,
      KEY,
      MULTI
   } scan_res_t;

   function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/kbd_col_scanner.sv
// Column drive sequencer and per-scan accumulator.
// The scan result and code are presented combinationally during the column-3 tick cycle.
module kbd_col_scanner
   import kbd_pkg::*;
#(
   parameter int TICK_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows_n,
   output logic [3:0] col_n,
   output logic       scan_done,
   output scan_res_t  scan_result,
   output logic [3:0] scan_code
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TCW-1:0] tick_cnt;
   logic [1:0]     col_idx;
   logic [1:0]     acc_lows;
   logic [3:0]     acc_code;
   logic           tick;
   logic [2:0]     lows_now;
   logic [1:0]     row_now;
   logic [2:0]     lows_sum;
   logic [1:0]     lows_sat;
   logic [3:0]     code_sum;

   assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

   always_comb begin
      lows_now = 3'd0;
      row_now  = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         lows_now = lows_now + 3'(!rows_n[r]);
         if (!rows_n[r]) row_now = 2'(r);
      end
      // Low-row count saturates at 2: anything beyond one hit is already MULTI.
      lows_sum = {1'b0, acc_lows} + lows_now;
      lows_sat = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
      code_sum = (acc_lows == 2'd0) ? key_code_of(row_now, col_idx) : acc_code;
   end

   assign scan_done   = tick && (col_idx == 2'd3);
   assign scan_code   = code_sum;
   assign scan_result = (lows_sat == 2'd0) ? NONE :
                        (lows_sat == 2'd1) ? KEY  : MULTI;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         col_idx  <= 2'd0;
         col_n    <= 4'b1110;
         acc_lows <= 2'd0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);
         if (tick) begin
            col_idx <= col_idx + 2'd1;
            col_n   <= ~(4'b0001 << (col_idx + 2'd1));
            if (col_idx == 2'd3) begin
               acc_lows <= 2'd0;
            end else begin
               acc_lows <= lows_sat;
               acc_code <= code_sum;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchroniser, column scan and scan-level debounce.
// Presses and releases are accepted only after DEBOUNCE_SCANS identical scans.
module keypad_scanner
   import kbd_pkg::*;
#(
   parameter int TICK_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]  row_s1;
   logic [3:0]  row_s2;
   logic        scan_done;
   scan_res_t   scan_result;
   logic [3:0]  scan_code;
   deb_state_t  state;
   logic [CW-1:0] deb_cnt;
   logic [3:0]  cand;
   logic        hit_held;
   logic        hit_cand;
   logic        cnt_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1 <= 4'b1111;
         row_s2 <= 4'b1111;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   kbd_col_scanner #(
      .TICK_DIV(TICK_DIV)
   ) u_col_scanner (
      .clk        (clk),
      .rst        (rst),
      .rows_n     (row_s2),
      .col_n      (col_n),
      .scan_done  (scan_done),
      .scan_result(scan_result),
      .scan_code  (scan_code)
   );

   assign hit_held = (scan_result == KEY) && (scan_code == key_code);
   assign hit_cand = (scan_result == KEY) && (scan_code == cand);
   assign cnt_full = ((deb_cnt + CW'(1)) == CW'(DEBOUNCE_SCANS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RELEASED;
         deb_cnt   <= '0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (scan_done) begin
            case (state)
               RELEASED: begin
                  if (scan_result == KEY) begin
                     cand <= scan_code;
                     if (DEBOUNCE_SCANS == 1) begin
                        state     <= PRESSED;
                        key_code  <= scan_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        deb_cnt   <= '0;
                     end else begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= CW'(1);
                     end
                  end
               end
               PRESS_WAIT: begin
                  if (hit_cand) begin
                     if (cnt_full) begin
                        state     <= PRESSED;
                        key_code  <= cand;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        deb_cnt   <= '0;
                     end else begin
                        deb_cnt <= deb_cnt + CW'(1);
                     end
                  end else if (scan_result == KEY) begin
                     cand    <= scan_code;
                     deb_cnt <= CW'(1);
                  end else begin
                     state   <= RELEASED;
                     deb_cnt <= '0;
                  end
               end
               PRESSED: begin
                  if (hit_held) begin
                     deb_cnt <= '0;
                  end else if (DEBOUNCE_SCANS == 1) begin
                     // A single clean scan already completes the release.
                     state    <= RELEASED;
                     key_held <= 1'b0;
                     deb_cnt  <= '0;
                  end else begin
                     state   <= RELEASE_WAIT;
                     deb_cnt <= CW'(1);
                  end
               end
               RELEASE_WAIT: begin
                  if (hit_held) begin
                     state   <= PRESSED;
                     deb_cnt <= '0;
                  end else if (cnt_full) begin
                     state    <= RELEASED;
                     key_held <= 1'b0;
                     deb_cnt  <= '0;
                  end else begin
                     deb_cnt <= deb_cnt + CW'(1);
                  end
               end
               default: begin
                  state   <= RELEASED;
                  deb_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
